// File: rtl/axi_pkg.sv
// axi_pkg: AXI burst/response encodings, channel FSM states and the
// burst-legality check shared by both channels of axi_burst_ram.
// Optional feature macro: AXI_RAM_WRAP_EN (accept WRAP bursts).
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_RAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

  // Whole-burst error: wrong beat size, reserved burst type, or a WRAP
  // burst that is disabled or has an illegal length.
  function automatic logic burst_bad(input logic [1:0] burst,
                                     input logic [7:0] len,
                                     input logic [2:0] size,
                                     input logic [2:0] exp_size);
    logic bad;
    logic wrap_len_ok;
    bad         = (size != exp_size);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (burst)
      BURST_FIXED, BURST_INCR: bad = bad;
      BURST_WRAP:              bad = bad | ~WRAP_EN | ~wrap_len_ok;
      default:                 bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/axi_if.sv
// axi_if: AXI4 channel bundle (no IDs/user). The snk modport is the
// slave view used by axi_burst_ram.
interface axi_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    aclk;
  logic                    aresetn;

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awlock;
  logic [3:0]              awregion;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arlock;
  logic [3:0]              arregion;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport snk (
    input  aclk, aresetn,
    input  awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awregion, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arcache, arprot, arlock, arregion, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_ram_addr_gen.sv
// axi_ram_addr_gen: next-beat address for FIXED/INCR/WRAP bursts and the
// out-of-range flag for the current beat address. Purely combinational.
module axi_ram_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTES      = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0]            burst_i,
  input  logic [7:0]            len_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  oob_o
);

  localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * longint'(BYTES);

  logic [ADDR_WIDTH-1:0] step_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // WRAP keeps the bits above the (len+1)*BYTES window and wraps inside it;
  // 4 KB crossings are deliberately not special-cased.
  always_comb begin
    step_addr = addr_i + ADDR_WIDTH'(BYTES);
    wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(BYTES)) - ADDR_WIDTH'(1);
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (step_addr & wrap_mask);
      default:     next_addr_o = step_addr;
    endcase
  end

  assign oob_o = 64'(addr_i) >= MEM_BYTES;

endmodule

// File: rtl/axi_burst_ram.sv
// axi_burst_ram: AXI4 burst slave backed by a MEM_DEPTH x DATA_WIDTH RAM.
// Write and read channels are independent FSMs; errors answer SLVERR.
// Optional feature macro: AXI_RAM_WRAP_EN (see axi_pkg).
module axi_burst_ram
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input logic aclk,
  input logic areset,
  axi_if.snk  s_axi
);

  localparam int         BYTES    = DATA_WIDTH / 8;
  localparam int         LSB      = $clog2(BYTES);
  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [2:0] EXP_SIZE = 3'(LSB);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // ---------------- write channel ----------------
  wr_state_e             wr_state_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            wr_len_q;
  logic [7:0]            wr_cnt_q;
  logic [1:0]            wr_burst_q;
  logic                  wr_bad_q;
  logic                  wr_err_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic [ADDR_WIDTH-1:0] wr_next_d;
  logic                  wr_oob_d;
  logic                  wr_hs_d;
  logic                  wr_last_d;
  logic                  wr_beat_err_d;
  logic                  wr_we_d;
  logic [IDX_W-1:0]      wr_idx_d;

  axi_ram_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYTES      (BYTES),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_wr_agen (
    .addr_i      (wr_addr_q),
    .burst_i     (wr_burst_q),
    .len_i       (wr_len_q),
    .next_addr_o (wr_next_d),
    .oob_o       (wr_oob_d)
  );

  // Beat qualification: awlen decides the end, wlast is only cross-checked.
  always_comb begin
    wr_hs_d       = s_axi.wvalid & wready_q;
    wr_last_d     = (wr_cnt_q == wr_len_q);
    wr_beat_err_d = wr_oob_d | (s_axi.wlast != wr_last_d);
    wr_we_d       = wr_hs_d & ~wr_bad_q & ~wr_oob_d;
    wr_idx_d      = wr_addr_q[LSB +: IDX_W];
  end

  // Byte-lane writes on the W handshake edge; contents survive reset.
  always_ff @(posedge aclk) begin
    if (wr_we_d) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi.wstrb[b]) mem_q[wr_idx_d][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // Write FSM: accept AW, take awlen+1 beats, then hold B until accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_burst_q <= BURST_INCR;
      wr_bad_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (s_axi.awvalid) begin
            wr_addr_q  <= s_axi.awaddr;
            wr_len_q   <= s_axi.awlen;
            wr_burst_q <= s_axi.awburst;
            wr_bad_q   <= burst_bad(s_axi.awburst, s_axi.awlen, s_axi.awsize, EXP_SIZE);
            wr_err_q   <= 1'b0;
            wr_cnt_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_hs_d) begin
            if (wr_last_d) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bresp_q    <= (wr_bad_q | wr_err_q | wr_beat_err_d) ? RESP_SLVERR : RESP_OKAY;
              wr_state_q <= W_RESP;
            end else begin
              wr_addr_q <= wr_next_d;
              wr_cnt_q  <= wr_cnt_q + 8'd1;
              wr_err_q  <= wr_err_q | wr_beat_err_d;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b1;
          wr_state_q <= W_IDLE;
        end
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;

  // ---------------- read channel ----------------
  rd_state_e             rd_state_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;   // address of the next beat to fetch
  logic [7:0]            rd_len_q;
  logic [7:0]            rd_cnt_q;    // index of the beat on the bus
  logic [1:0]            rd_burst_q;
  logic                  rd_bad_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0] rd_ld_addr_d;
  logic [1:0]            rd_ld_burst_d;
  logic [7:0]            rd_ld_len_d;
  logic [ADDR_WIDTH-1:0] rd_next_d;
  logic                  rd_oob_d;
  logic                  ar_bad_d;
  logic                  rd_beat_err_d;
  logic [DATA_WIDTH-1:0] rd_word_d;
  logic                  rd_hs_d;

  // The fetch address comes straight from AR in idle so beat 0 is ready
  // the cycle after the AR handshake.
  always_comb begin
    ar_bad_d      = burst_bad(s_axi.arburst, s_axi.arlen, s_axi.arsize, EXP_SIZE);
    rd_ld_addr_d  = (rd_state_q == R_IDLE) ? s_axi.araddr  : rd_addr_q;
    rd_ld_burst_d = (rd_state_q == R_IDLE) ? s_axi.arburst : rd_burst_q;
    rd_ld_len_d   = (rd_state_q == R_IDLE) ? s_axi.arlen   : rd_len_q;
    rd_hs_d       = rvalid_q & s_axi.rready;
  end

  axi_ram_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYTES      (BYTES),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_rd_agen (
    .addr_i      (rd_ld_addr_d),
    .burst_i     (rd_ld_burst_d),
    .len_i       (rd_ld_len_d),
    .next_addr_o (rd_next_d),
    .oob_o       (rd_oob_d)
  );

  // Errored beats return zero data with SLVERR.
  always_comb begin
    rd_beat_err_d = ((rd_state_q == R_IDLE) ? ar_bad_d : rd_bad_q) | rd_oob_d;
    rd_word_d     = rd_beat_err_d ? '0 : mem_q[rd_ld_addr_d[LSB +: IDX_W]];
  end

  // Read FSM: one beat per accepted R, outputs frozen while stalled.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_burst_q <= BURST_INCR;
      rd_bad_q   <= 1'b0;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (s_axi.arvalid) begin
            rd_addr_q  <= rd_next_d;
            rd_len_q   <= s_axi.arlen;
            rd_burst_q <= s_axi.arburst;
            rd_bad_q   <= ar_bad_d;
            rd_cnt_q   <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_word_d;
            rresp_q    <= rd_beat_err_d ? RESP_SLVERR : RESP_OKAY;
            rlast_q    <= (s_axi.arlen == 8'd0);
            rd_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rd_hs_d) begin
            if (rlast_q) begin
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              arready_q  <= 1'b1;
              rd_state_q <= R_IDLE;
            end else begin
              rd_addr_q <= rd_next_d;
              rd_cnt_q  <= rd_cnt_q + 8'd1;
              rdata_q   <= rd_word_d;
              rresp_q   <= rd_beat_err_d ? RESP_SLVERR : RESP_OKAY;
              rlast_q   <= ((rd_cnt_q + 8'd1) == rd_len_q);
            end
          end
        end
        default: begin
          rvalid_q   <= 1'b0;
          rlast_q    <= 1'b0;
          arready_q  <= 1'b1;
          rd_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  // Attributes this RAM does not interpret.
  logic unused_attr;
  assign unused_attr = ^{s_axi.aclk, s_axi.aresetn,
                         s_axi.awcache, s_axi.awprot, s_axi.awlock, s_axi.awregion, s_axi.awqos,
                         s_axi.arcache, s_axi.arprot, s_axi.arlock, s_axi.arregion, s_axi.arqos};

endmodule

// File: tb/tb_axi_burst_ram.sv
// tb_axi_burst_ram: directed and randomized bursts against a byte-array
// reference model of the RAM.
`timescale 1ns/1ps
module tb_axi_burst_ram;

  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int DEPTH     = 1024;
  localparam int MEM_BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_axi ();

  axi_burst_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .aclk   (clk),
    .areset (rst),
    .s_axi  (s_axi)
  );

  int       n_cmp = 0;
  int       n_bad = 0;
  bit       wrap_en;
  logic [7:0] mdl [MEM_BYTES];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_burst_bad(input logic [1:0] b, input logic [7:0] len, input logic [2:0] sz);
    if (sz != 3'd2) return 1'b1;
    if (b == 2'b11) return 1'b1;
    if (b == 2'b10) return !(wrap_en && (len == 1 || len == 3 || len == 7 || len == 15));
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [7:0] len,
                                         input logic [1:0] b, input int i);
    logic [31:0] total, base;
    if (b == 2'b00) return a;
    if (b == 2'b10) begin
      total = (32'(len) + 32'd1) * 32'd4;
      base  = a - (a % total);
      return base + ((a - base + 32'(4 * i)) % total);
    end
    return a + 32'(4 * i);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int w;
    w = int'(a & ~32'h3);
    return {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b,
                           input logic [2:0] sz, input logic [31:0] d [16], input logic [3:0] st [16],
                           input int bad_last, input bit gaps, output logic [1:0] resp);
    int n;
    bit err, bb;
    logic [31:0] ba;
    bb  = m_burst_bad(b, len, sz);
    err = bb;
    @(negedge clk);
    s_axi.awaddr = a; s_axi.awlen = len; s_axi.awburst = b; s_axi.awsize = sz;
    s_axi.awvalid = 1'b1;
    n = 0;
    while (!s_axi.awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("aw_timeout", 1, 0);
    @(negedge clk);
    s_axi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin s_axi.wvalid = 1'b0; @(negedge clk); end
      s_axi.wdata  = d[i];
      s_axi.wstrb  = st[i];
      s_axi.wlast  = (i == int'(len)) ^ (i == bad_last);
      s_axi.wvalid = 1'b1;
      n = 0;
      while (!s_axi.wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("w_timeout", 1, 0);
      @(negedge clk);
      ba = m_addr(a, len, b, i);
      if (i == bad_last) err = 1'b1;
      if (ba >= 32'(MEM_BYTES)) err = 1'b1;
      else if (!bb)
        for (int k = 0; k < 4; k++)
          if (st[i][k]) mdl[int'(ba & ~32'h3) + k] = d[i][8*k +: 8];
    end
    s_axi.wvalid = 1'b0;
    s_axi.wlast  = 1'b0;
    chk("bvalid_lat", s_axi.bvalid, 1);
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    chk("bvalid_hold", s_axi.bvalid, 1);
    s_axi.bready = 1'b1;
    resp = s_axi.bresp;
    chk("bresp", s_axi.bresp, err ? 2'b10 : 2'b00);
    @(negedge clk);
    s_axi.bready = 1'b0;
    chk("bvalid_end", s_axi.bvalid, 0);
    chk("awready_end", s_axi.awready, 1);
  endtask

  // rmode: 0 always ready, 1 random, 2 toggle 1,0,1,0...
  task automatic axi_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b,
                          input logic [2:0] sz, input int rmode,
                          output logic [31:0] got [16], output logic [1:0] rs [16]);
    int n, i, cyc;
    bit bb, rdy, tog, e_err;
    logic [31:0] ba, e_data;
    bb = m_burst_bad(b, len, sz);
    @(negedge clk);
    s_axi.araddr = a; s_axi.arlen = len; s_axi.arburst = b; s_axi.arsize = sz;
    s_axi.arvalid = 1'b1;
    n = 0;
    while (!s_axi.arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ar_timeout", 1, 0);
    @(negedge clk);
    s_axi.arvalid = 1'b0;
    chk("rvalid_lat", s_axi.rvalid, 1);
    i = 0; cyc = 0; tog = 1'b1;
    while (i <= int'(len) && cyc < 200) begin
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : tog;
      tog = !tog;
      s_axi.rready = rdy;
      ba     = m_addr(a, len, b, i);
      e_err  = bb || (ba >= 32'(MEM_BYTES));
      e_data = e_err ? 32'h0 : m_word(ba);
      chk("rvalid", s_axi.rvalid, 1);
      chk("rdata", s_axi.rdata, e_data);
      chk("rresp", s_axi.rresp, e_err ? 2'b10 : 2'b00);
      chk("rlast", s_axi.rlast, i == int'(len));
      if (rdy) begin got[i] = s_axi.rdata; rs[i] = s_axi.rresp; i++; end
      @(negedge clk);
      cyc++;
    end
    s_axi.rready = 1'b0;
    if (cyc >= 200) chk("r_timeout", 1, 0);
    chk("rvalid_end", s_axi.rvalid, 0);
    chk("arready_end", s_axi.arready, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] d [16];
    logic [3:0]  st [16];
    logic [31:0] got [16];
    logic [1:0]  rs [16];
    logic [1:0]  r;
    logic [31:0] a, d0, d1;
    logic [7:0]  len;
    logic [1:0]  b;
    logic [2:0]  sz;
    int          pick, bl;

`ifdef AXI_RAM_WRAP_EN
    wrap_en = 1'b1;
`else
    wrap_en = 1'b0;
`endif
    s_axi.aclk = 1'b0; s_axi.aresetn = 1'b1;
    s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = 3'd2; s_axi.awburst = 2'b01;
    s_axi.awcache = '0; s_axi.awprot = '0; s_axi.awlock = 1'b0; s_axi.awregion = '0; s_axi.awqos = '0;
    s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
    s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = 3'd2; s_axi.arburst = 2'b01;
    s_axi.arcache = '0; s_axi.arprot = '0; s_axi.arlock = 1'b0; s_axi.arregion = '0; s_axi.arqos = '0;
    s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
    for (int i = 0; i < 16; i++) begin d[i] = '0; st[i] = 4'hF; got[i] = '0; rs[i] = '0; end

    repeat (3) @(negedge clk);
    chk("rst_awready", s_axi.awready, 1);
    chk("rst_arready", s_axi.arready, 1);
    chk("rst_wready",  s_axi.wready, 0);
    chk("rst_bvalid",  s_axi.bvalid, 0);
    chk("rst_rvalid",  s_axi.rvalid, 0);
    chk("rst_rlast",   s_axi.rlast, 0);
    chk("rst_bresp",   s_axi.bresp, 0);
    chk("rst_rresp",   s_axi.rresp, 0);
    chk("rst_rdata",   s_axi.rdata, 0);
    rst = 1'b0;

    // Fill the whole RAM so the model is fully known.
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      for (int i = 0; i < 16; i++) begin d[i] = $urandom; st[i] = 4'hF; end
      axi_write(32'(blk * 64), 8'd15, 2'b01, 3'd2, d, st, -1, 1'b0, r);
    end

    // INCR len=3 round trip.
    for (int i = 0; i < 16; i++) begin d[i] = 32'hA0 + 32'(i); st[i] = 4'hF; end
    axi_write(32'h10, 8'd3, 2'b01, 3'd2, d, st, -1, 1'b0, r);
    chk("t_incr_bresp", r, 2'b00);
    axi_read(32'h10, 8'd3, 2'b01, 3'd2, 0, got, rs);
    for (int i = 0; i < 4; i++) chk("t_incr_data", got[i], 32'hA0 + 32'(i));

    // Byte strobes.
    d[0] = 32'h11223344; st[0] = 4'hF;
    axi_write(32'h0, 8'd0, 2'b01, 3'd2, d, st, -1, 1'b0, r);
    d[0] = 32'hDEADBEEF; st[0] = 4'b0011;
    axi_write(32'h0, 8'd0, 2'b01, 3'd2, d, st, -1, 1'b0, r);
    axi_read(32'h0, 8'd0, 2'b01, 3'd2, 0, got, rs);
    chk("t_strb_data", got[0], 32'h1122BEEF);
    st[0] = 4'hF;

    // Toggling rready on a len=7 read.
    for (int i = 0; i < 16; i++) d[i] = $urandom;
    axi_write(32'h100, 8'd7, 2'b01, 3'd2, d, st, -1, 1'b1, r);
    axi_read(32'h100, 8'd7, 2'b01, 3'd2, 2, got, rs);
    for (int i = 0; i < 8; i++) chk("t_stall_data", got[i], d[i]);

    // Out of range (also catches aliasing onto word 0).
    d[0] = 32'hCAFEF00D;
    axi_write(32'h1000, 8'd0, 2'b01, 3'd2, d, st, -1, 1'b0, r);
    chk("t_oob_bresp", r, 2'b10);
    axi_read(32'h1000, 8'd0, 2'b01, 3'd2, 0, got, rs);
    chk("t_oob_rdata", got[0], 32'h0);
    chk("t_oob_rresp", rs[0], 2'b10);
    axi_read(32'h0, 8'd0, 2'b01, 3'd2, 0, got, rs);
    chk("t_oob_alias", got[0], 32'h1122BEEF);

    // Early and missing wlast.
    axi_write(32'h200, 8'd3, 2'b01, 3'd2, d, st, 1, 1'b0, r);
    chk("t_early_wlast", r, 2'b10);
    axi_write(32'h200, 8'd3, 2'b01, 3'd2, d, st, 3, 1'b0, r);
    chk("t_miss_wlast", r, 2'b10);

    // WRAP len=3 at 0x08.
    for (int i = 0; i < 4; i++) d[i] = 32'hB0 + 32'(i);
    axi_write(32'h08, 8'd3, 2'b10, 3'd2, d, st, -1, 1'b0, r);
    chk("t_wrap_bresp", r, wrap_en ? 2'b00 : 2'b10);
    axi_read(32'h00, 8'd3, 2'b01, 3'd2, 0, got, rs);
    if (wrap_en) begin
      chk("t_wrap_w0", got[0], 32'hB2); chk("t_wrap_w1", got[1], 32'hB3);
      chk("t_wrap_w2", got[2], 32'hB0); chk("t_wrap_w3", got[3], 32'hB1);
    end
    axi_read(32'h08, 8'd3, 2'b10, 3'd2, 1, got, rs);
    chk("t_wrap_rresp", rs[0], wrap_en ? 2'b00 : 2'b10);

    // Wrong size: whole burst errored.
    axi_write(32'h300, 8'd1, 2'b01, 3'd1, d, st, -1, 1'b0, r);
    chk("t_size_bresp", r, 2'b10);

    // Reset during beat 2 of a len=7 write.
    d0 = $urandom; d1 = $urandom;
    @(negedge clk);
    s_axi.awaddr = 32'h40; s_axi.awlen = 8'd7; s_axi.awburst = 2'b01; s_axi.awsize = 3'd2;
    s_axi.awvalid = 1'b1;
    @(negedge clk);
    s_axi.awvalid = 1'b0;
    s_axi.wdata = d0; s_axi.wstrb = 4'hF; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b1;
    chk("t_rst_wready", s_axi.wready, 1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) mdl[32'h40 + k] = d0[8*k +: 8];
    s_axi.wdata = d1;
    rst = 1'b1;
    @(negedge clk);
    s_axi.wvalid = 1'b0;
    chk("t_rst_awready", s_axi.awready, 1);
    chk("t_rst_wready0", s_axi.wready, 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin chk("t_rst_bvalid", s_axi.bvalid, 0); @(negedge clk); end
    axi_read(32'h40, 8'd1, 2'b01, 3'd2, 0, got, rs);
    chk("t_rst_beat1", got[0], d0);

    // Concurrent write and read on disjoint regions.
    for (int i = 0; i < 16; i++) d[i] = $urandom;
    fork
      axi_write(32'h400, 8'd15, 2'b01, 3'd2, d, st, -1, 1'b1, r);
      axi_read(32'h800, 8'd15, 2'b01, 3'd2, 1, got, rs);
    join
    axi_read(32'h400, 8'd15, 2'b01, 3'd2, 1, got, rs);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      a = 32'($urandom_range(0, 32'h1100));
      if ($urandom_range(0, 7) != 0) a = a & ~32'h3;
      len  = 8'($urandom_range(0, 15));
      pick = $urandom_range(0, 9);
      if (pick <= 5) b = 2'b01;
      else if (pick <= 7) b = 2'b00;
      else if (pick == 8) begin
        b = 2'b10;
        if ($urandom_range(0, 3) != 0) len = 8'((1 << $urandom_range(1, 4)) - 1);
      end else b = 2'b11;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      for (int i = 0; i < 16; i++) begin d[i] = $urandom; st[i] = 4'($urandom); end
      bl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      if ($urandom_range(0, 1) == 1) axi_write(a, len, b, sz, d, st, bl, 1'b1, r);
      else                           axi_read(a, len, b, sz, 1, got, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
